spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//   Parametrised SPI Mode-0 register bank; successor to the 5x8-bit write-only SPI peripheral.
//   Adds configurable register count/widths, read-back on CIPO, per-register write strobes, error flag.
//   Sits between ui_in SPI pins and PWM/output-enable logic in the top level; all logic on clk.
// PARAMETERS
//   NUM_REGS     5  number of implemented registers, addresses 0..NUM_REGS-1
//   DATA_W       8  register / data-field width in bits
//   ADDR_W       7  address-field width in bits; FRAME_W = 1 + ADDR_W + DATA_W
//   SYNC_STAGES  2  synchroniser depth for sclk/copi/ncs, >= 2
// PORTS
//   clk        in   1                system clock (10 MHz nominal)
//   rst_n      in   1                reset, synchronous, active-low
//   sclk       in   1                SPI clock, async
//   copi       in   1                SPI data in, async, MSB first
//   ncs        in   1                SPI chip select, async, active-low
//   cipo       out  1                SPI data out
//   cipo_oe    out  1                1 while synchronised ncs is low
//   regs_flat  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe  out  NUM_REGS         1-cycle pulse on the cycle reg i is written
//   err        out  1                sticky: bad address or malformed frame
//   err_clr    in   1                clears err (set wins if same cycle)
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): regs_flat=0, wr_strobe=0, err=0, cipo=0, cipo_oe=0, FSM=IDLE.
//   ncs sync flops reset to 0: no frame starts until ncs observed high >=1 cycle after reset.
//   Frame: bit0 R/W (1=write), then ADDR_W addr bits, then DATA_W data bits; sampled on synced sclk rise.
//   FSM: IDLE -(ncs fall)-> ADDR -(1+ADDR_W bits)-> DATA -(DATA_W bits)-> DONE -(ncs rise)-> IDLE.
//     ncs rise in any state -> IDLE; sclk edges while ncs high ignored.
//   Write: committed on cycle after ncs rise detected, only if exactly FRAME_W bits received;
//     wr_strobe[addr] pulses on that same cycle.
//   Read: on last addr bit, tx shift loads reg[addr]; cipo = tx MSB; shifts on each synced sclk fall.
//     Write frames drive cipo=0. SCLK <= clk/8 required for valid reads.
//   addr >= NUM_REGS: write dropped, read returns 0, err set at ncs rise.
//   Bit count != FRAME_W at ncs rise (short/overrun): no write, err set; regs unchanged.
//   Reset mid-frame: frame abandoned, no partial write, FSM IDLE.
// CONFIGURATION
//   SPI_BURST_EN defined: after DATA, further DATA_W-bit words target addr+1, addr+2, ...
//     Writes commit (+wr_strobe) on the cycle after each word's last bit, not at ncs rise;
//     reads prefetch next reg at each word boundary; addr past NUM_REGS-1 -> err, writes dropped.
//     Trailing partial word at ncs rise discarded, err set; completed words kept.
//   SPI_BURST_EN undefined: bits beyond FRAME_W -> overrun rule above.
// STRUCTURE
//   Package spi_reg_pkg: state enum (IDLE/ADDR/DATA/DONE), RW_WRITE constant, FRAME_W function.
//   Sub-module spi_sync: SYNC_STAGES-deep synchroniser + rise/fall pulses, one instance per pin.
//   Top: FSM, bit counter, rx/tx shift registers, register array, err logic.
// TESTING
//   Write 0x80A5 (defaults: addr 0, data 0xA5) -> reg0=0xA5, wr_strobe[0] one pulse, err=0.
//   Write addr 4 data 0x7F then read addr 4 -> cipo returns 0x7F MSB first, regs unchanged.
//   Write addr 5 (>=NUM_REGS) -> no reg change, no strobe, err=1; err_clr pulse -> err=0.
//   12-bit frame then 17-bit frame -> no writes, err=1 after each.
//   rst_n low mid-frame (after 9 bits) -> all regs 0, next full frame writes normally.
//   SPI_BURST_EN: write addr 1 + 0x11,0x22,0x33 -> reg1..3 = 11/22/33, three strobes in order.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI Mode-0 register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w + 32'sd1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an SPI controller (master) and the register bank (slave).
interface spi_reg_bank_if;
  logic sclk;
  logic copi;
  logic ncs;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output copi, output ncs, input cipo, input cipo_oe);
  modport slave  (input sclk, input copi, input ncs, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              last_r;

  // synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {STAGES{1'b0}};
      last_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      last_r <= sync_r[STAGES-1];
    end
  end

  assign dout = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~last_r;
  assign fall = ~sync_r[STAGES-1] & last_r;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI Mode-0 register bank: write/read registers over SPI, sticky error flag.
// Build option SPI_BURST_EN: auto-incrementing multi-word frames.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0] ADDR_MAX = {AW1{1'b1}};

  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic copi_s, copi_rise_s, copi_fall_s;
  logic ncs_s, ncs_rise_s, ncs_fall_s;
  logic unused_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .din(spi.sclk),
    .dout(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst_n(rst_n), .din(spi.copi),
    .dout(copi_s), .rise(copi_rise_s), .fall(copi_fall_s));
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ncs (.clk(clk), .rst_n(rst_n), .din(spi.ncs),
    .dout(ncs_s), .rise(ncs_rise_s), .fall(ncs_fall_s));

  assign unused_s = ^{sclk_s, copi_rise_s, copi_fall_s};

  spi_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] hdr_r;
  logic [DATA_W-2:0] dat_r;
  logic              rw_r;
  logic [AW1-1:0]    cur_addr_r;
  logic [DATA_W-1:0] tx_r;
  logic              tx_skip_r;
  logic              cipo_oe_r;
  logic              err_r;
  logic [NUM_REGS-1:0] wr_strobe_r;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
`ifdef SPI_BURST_EN
  logic              any_word_r;
`else
  logic              ovr_r;
  logic [DATA_W-1:0] wdata_r;
`endif

  logic [ADDR_W:0]   hdr_nxt_s;
  logic [DATA_W-1:0] dat_nxt_s;
  logic [AW1-1:0]    rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;
  logic              addr_ok_s;

  assign hdr_nxt_s = {hdr_r, copi_s};
  assign dat_nxt_s = {dat_r, copi_s};
  assign addr_ok_s = (cur_addr_r < AW1'(NUM_REGS));
  // header decode reads the incoming address; in a burst it prefetches the next one
  assign rd_addr_s = (state_r == ADDR) ? {1'b0, hdr_nxt_s[ADDR_W-1:0]} : cur_addr_r + AW1'(1);

  // read-back mux; unimplemented addresses read as zero
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_s == AW1'(i)) rd_data_s = regs_r[i];
      else                      rd_data_s = rd_data_s;
    end
  end

  // frame FSM, shift registers, register array and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_W'(0);
      hdr_r       <= {ADDR_W{1'b0}};
      dat_r       <= {(DATA_W-1){1'b0}};
      rw_r        <= 1'b0;
      cur_addr_r  <= {AW1{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      tx_skip_r   <= 1'b0;
      cipo_oe_r   <= 1'b0;
      err_r       <= 1'b0;
      wr_strobe_r <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
`ifdef SPI_BURST_EN
      any_word_r  <= 1'b0;
`else
      ovr_r       <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
`endif
    end else begin
      wr_strobe_r <= {NUM_REGS{1'b0}};
      cipo_oe_r   <= ~ncs_s;
      if (err_clr) err_r <= 1'b0;
      if (ncs_rise_s) begin
        state_r   <= IDLE;
        tx_r      <= {DATA_W{1'b0}};
        tx_skip_r <= 1'b0;
        if (state_r != IDLE) begin
`ifdef SPI_BURST_EN
          if (state_r != DATA || cnt_r != CNT_W'(0) || !any_word_r) err_r <= 1'b1;
`else
          if (state_r != DONE || ovr_r || !addr_ok_s) begin
            err_r <= 1'b1;
          end else if (rw_r == RW_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (cur_addr_r == AW1'(i)) begin
                regs_r[i]      <= wdata_r;
                wr_strobe_r[i] <= 1'b1;
              end
            end
          end
`endif
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (ncs_fall_s) begin
              state_r <= ADDR;
              cnt_r   <= CNT_W'(0);
`ifdef SPI_BURST_EN
              any_word_r <= 1'b0;
`else
              ovr_r      <= 1'b0;
`endif
            end
          end
          ADDR: begin
            if (sclk_rise_s) begin
              hdr_r <= hdr_nxt_s[ADDR_W-1:0];
              if (cnt_r == CNT_W'(ADDR_W)) begin
                state_r    <= DATA;
                cnt_r      <= CNT_W'(0);
                rw_r       <= hdr_nxt_s[ADDR_W];
                cur_addr_r <= {1'b0, hdr_nxt_s[ADDR_W-1:0]};
                tx_r       <= (hdr_nxt_s[ADDR_W] == RW_WRITE) ? {DATA_W{1'b0}} : rd_data_s;
                tx_skip_r  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sclk_rise_s) begin
              dat_r <= dat_nxt_s[DATA_W-2:0];
              if (cnt_r == CNT_W'(DATA_W - 1)) begin
                cnt_r <= CNT_W'(0);
`ifdef SPI_BURST_EN
                any_word_r <= 1'b1;
                if (!addr_ok_s) begin
                  err_r <= 1'b1;
                end else if (rw_r == RW_WRITE) begin
                  for (int i = 0; i < NUM_REGS; i++) begin
                    if (cur_addr_r == AW1'(i)) begin
                      regs_r[i]      <= dat_nxt_s;
                      wr_strobe_r[i] <= 1'b1;
                    end
                  end
                end
                if (cur_addr_r != ADDR_MAX) cur_addr_r <= cur_addr_r + AW1'(1);
                tx_r      <= (rw_r == RW_WRITE) ? {DATA_W{1'b0}} : rd_data_s;
                tx_skip_r <= 1'b1;
`else
                state_r <= DONE;
                wdata_r <= dat_nxt_s;
`endif
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          DONE: begin
`ifndef SPI_BURST_EN
            if (sclk_rise_s) ovr_r <= 1'b1;
`endif
          end
          default: state_r <= IDLE;
        endcase
        // the first falling edge after a load only ends the previous bit, so skip it
        if (sclk_fall_s && state_r != IDLE) begin
          if (tx_skip_r) tx_skip_r <= 1'b0;
          else           tx_r      <= {tx_r[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign wr_strobe   = wr_strobe_r;
  assign err         = err_r;
  assign spi.cipo    = tx_r[DATA_W-1];
  assign spi.cipo_oe = cipo_oe_r;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: random and directed SPI frames against a frame-level model.
module tb_spi_reg_bank;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int HALF     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic err;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0] wr_strobe;

  spi_reg_bank_if spi ();

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .err(err), .err_clr(err_clr));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_regs [NUM_REGS];
  logic       model_err;
  int         exp_wr_idx [$];
  logic [7:0] exp_wr_dat [$];
  logic [7:0] exp_rd_q [$];
  logic [7:0] obs_rd_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] flat_model();
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < NUM_REGS; i++) r[i*8 +: 8] = model_regs[i];
    return r;
  endfunction

  // monitor: pops expectations whenever the DUT strobes a write or a read word completes
  always @(negedge clk) begin
    int i;
    logic [7:0] d;
    if (rst_n && wr_strobe != 5'd0) begin
      if (exp_wr_idx.size() == 0) begin
        check("unexpected_strobe", 64'(wr_strobe), 64'd0);
      end else begin
        i = exp_wr_idx.pop_front();
        d = exp_wr_dat.pop_front();
        check("wr_strobe", 64'(wr_strobe), 64'(5'b00001 << i));
        check("wr_data", 64'(regs_flat[i*8 +: 8]), 64'(d));
      end
    end
    if (obs_rd_q.size() > 0) begin
      d = obs_rd_q.pop_front();
      if (exp_rd_q.size() == 0) check("unexpected_read", 64'(d), 64'hdead);
      else                      check("cipo_word", 64'(d), 64'(exp_rd_q.pop_front()));
    end
  end

  task automatic spi_bit(input bit b);
    spi.copi = b;
    repeat (HALF) @(negedge clk);
    spi.sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi.sclk = 1'b0;
  endtask

  task automatic run_frame(input bit rw, input int addr, input int nbits, input logic [31:0] dat);
    bit fq [$];
    int words, rem, a;
    logic [7:0] w, cap;
    fq.push_back(rw);
    for (int i = ADDR_W - 1; i >= 0; i--) fq.push_back(addr[i]);
    for (int j = 0; j < 32; j++) fq.push_back(dat[31-j]);
    while (fq.size() < nbits) fq.push_back(1'($urandom_range(0, 1)));
    while (fq.size() > nbits) void'(fq.pop_back());
`ifdef SPI_BURST_EN
    words = (nbits >= 16) ? (nbits - 8) / 8 : 0;
    rem   = (nbits >= 8) ? (nbits - 8) % 8 : 1;
    if (nbits < 16 || rem != 0) model_err = 1'b1;
`else
    words = (nbits >= 16) ? 1 : 0;
    if (nbits != 16 || addr >= NUM_REGS) model_err = 1'b1;
`endif
    for (int k = 0; k < words; k++) begin
      a = addr + k;
      for (int b = 0; b < 8; b++) w[7-b] = fq[8 + 8*k + b];
      exp_rd_q.push_back((rw || a >= NUM_REGS) ? 8'h00 : model_regs[a]);
`ifdef SPI_BURST_EN
      if (a >= NUM_REGS) model_err = 1'b1;
      else if (rw) begin
        model_regs[a] = w;
        exp_wr_idx.push_back(a);
        exp_wr_dat.push_back(w);
      end
`else
      if (rw && nbits == 16 && a < NUM_REGS) begin
        model_regs[a] = w;
        exp_wr_idx.push_back(a);
        exp_wr_dat.push_back(w);
      end
`endif
    end
    cap = 8'h00;
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi.copi = fq[i];
      repeat (HALF) @(negedge clk);
      if (i == 0) check("cipo_oe_active", 64'(spi.cipo_oe), 64'd1);
      if (i >= 8) begin
        cap = {cap[6:0], spi.cipo};
        if ((i - 8) % 8 == 7 && (i - 8) / 8 < words) obs_rd_q.push_back(cap);
      end
      spi.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi.ncs = 1'b1;
    repeat (12) @(negedge clk);
    check("err", 64'(err), 64'(model_err));
    check("regs", 64'(regs_flat), flat_model());
    check("cipo_oe_idle", 64'(spi.cipo_oe), 64'd0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    check("err_clr", 64'(err), 64'd0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    model_err = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_regs", 64'(regs_flat), 64'd0);
    check("rst_strobe", 64'(wr_strobe), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cipo", 64'(spi.cipo), 64'd0);
    check("rst_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run_frame(1'b1, 0, 16, 32'hA500_0000);
    run_frame(1'b1, 4, 16, 32'h7F00_0000);
    run_frame(1'b0, 4, 16, 32'h0000_0000);
    run_frame(1'b1, 5, 16, 32'h5A00_0000);
    pulse_clr();
    run_frame(1'b1, 1, 12, 32'h3C00_0000);
    pulse_clr();
    run_frame(1'b1, 2, 17, 32'h6600_0000);
    pulse_clr();

    // reset in the middle of a write frame
    spi.ncs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bit(1'b1);
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    model_err = 1'b0;
    check("abort_regs", 64'(regs_flat), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_cipo_oe", 64'(spi.cipo_oe), 64'd0);
    spi.ncs = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(1'b1, 3, 16, 32'hC300_0000);

`ifdef SPI_BURST_EN
    run_frame(1'b1, 1, 32, 32'h1122_3300);
    run_frame(1'b0, 1, 32, 32'h0000_0000);
`endif

    for (int n = 0; n < 30; n++) begin
      bit rw;
      int addr, nbits;
      rw = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                         : int'($urandom_range(0, NUM_REGS - 1));
`ifdef SPI_BURST_EN
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                          : 8 + 8 * int'($urandom_range(1, 3));
`else
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 16;
`endif
      run_frame(rw, addr, nbits, $urandom);
      if (n % 5 == 4) pulse_clr();
    end

    repeat (20) @(negedge clk);
    check("wr_queue_drained", 64'(exp_wr_idx.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
